// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter must index WIDTH positions but never shrink below one bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/done operand and result bundle between a parent and the serial adder.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             busy;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             done;

    modport master (
        output start, a, b, cin,
        input  ready, busy, sum, cout, done
    );

    modport slave (
        input  start, a, b, cin,
        output ready, busy, sum, cout, done
    );
endinterface

// File: rtl/full_adder.sv
// One-bit combinational full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell and a registered carry produce a + b + cin
// over WIDTH clocks; results are published only when the last bit is done.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             cout_q;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;

    full_adder u_fa (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .cin (carry),
        .sum (fa_sum),
        .cout(fa_cout)
    );

    assign last_bit = (cnt == LAST_BIT);
    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign res_next = (res_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

    always_comb begin
        // NOTE: default assigned first so no path through the case can infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_bit)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every register, datapath included, clears on reset so no stale partial result survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        carry <= bus.cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_cout;
                    res_sh <= res_next;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        sum_q  <= res_next;
                        cout_q <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready = (state == IDLE);
    assign bus.busy  = (state != IDLE);
    assign bus.done  = (state == DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder that computes `a + b + cin` one bit per clock through a single `full_adder` cell and a registered carry. It sits directly downstream of the combinational `full_adder`: it sequences operands into that cell and collects its `sum`/`cout` outputs. It is the area-minimal alternative to a ripple-carry adder, used wherever latency of WIDTH cycles is acceptable. It is a start/done block; the parent presents operands and waits for `done`.

## Interface

Parameters:
- `WIDTH` — default 8 — operand and result width in bits; legal range ≥ 1.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `start`  in  1  — request a new addition; sampled only when `ready`=1.
- `a`  in  WIDTH  — operand A; sampled on the accepting edge only.
- `b`  in  WIDTH  — operand B; sampled on the accepting edge only.
- `cin`  in  1  — carry-in; sampled on the accepting edge only.
- `ready`  out  1  — block idle and able to accept `start`.
- `busy`  out  1  — operation in progress (state RUN or DONE); always the inverse of `ready`.
- `sum`  out  WIDTH  — result of the last completed operation.
- `cout`  out  1  — carry-out of the last completed operation.
- `done`  out  1  — single-cycle pulse; `sum`/`cout` are valid from this cycle on.

## Operation

- FSM with three states: IDLE, RUN, DONE.
- **IDLE** (`ready`=1):
  - On `start`=1 at edge k: load `a`, `b` into right-shift registers, load the carry register with `cin`, clear the bit counter, go to RUN.
- **RUN** (one bit per edge):
  - The `full_adder` inputs are the operand shift-register LSBs and the carry register.
  - Its `sum` is shifted into the MSB of an internal result shift register; its `cout` is written to the carry register.
  - Operand registers shift right; the counter increments.
  - On the edge that processes bit WIDTH-1, go to DONE and copy the result shift register and final carry into `sum` and `cout`.
- **DONE**: `done`=1 for exactly one cycle; next edge goes to IDLE.
- Output stability:
  - `sum` and `cout` change only on the edge that enters DONE.
  - They hold until the next operation completes or until reset.
  - No partial results are ever visible.
- Arithmetic: `{cout, sum}` = `a + b + cin`, modulo 2^(WIDTH+1); unsigned; no overflow flag.
- Boundary conditions:
  - `start` while `busy`=1 is ignored; no queueing, no restart.
  - Changes to `a`, `b`, `cin` after the accepting edge have no effect.
  - `start` held high continuously launches a new operation on the first IDLE cycle after each DONE.
  - WIDTH=1: RUN lasts one edge.
  - Reset mid-operation abandons the operation; `done` never pulses for it.
- Reset values: state IDLE, `ready`=1, `busy`=0, `done`=0, `sum`=0, `cout`=0. Internal shift, carry and counter registers also clear to 0.

## Timing

- `start` accepted at edge k ⇒ RUN processes bits at edges k+1 … k+WIDTH.
- `done`=1 in the cycle following edge k+WIDTH, i.e. latency WIDTH cycles from the accepting edge.
- `ready` returns at edge k+WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles (minimum start-to-start spacing).
- `done`, `ready`, `busy`, `sum`, `cout` are all registered (no combinational path from inputs).
- `rst` high at any edge ⇒ reset values visible in the following cycle, regardless of state or `start`.
- Counter width: $clog2(WIDTH) bits, minimum 1.

## Structure

- Shared package holds the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) as named constants.
- One sub-module instance: the existing `full_adder` (ports a, b, cin, sum, cout); no other hierarchy.
- Single always block for all sequential state, plus continuous assigns for `ready`/`busy`.

## Test plan

- WIDTH=8, a=8'h00, b=8'h00, cin=0 → `sum`=8'h00, `cout`=0. `done` high exactly 8 cycles after the accepting edge, for one cycle; `ready` returns the cycle after.
- a=8'hFF, b=8'h01, cin=0 → `sum`=8'h00, `cout`=1. Then a=8'hFF, b=8'hFF, cin=1 → `sum`=8'hFF, `cout`=1.
- a=8'h3C, b=8'hA5, cin=0. At RUN cycle 3 drive a=8'hFF, b=8'hFF and pulse `start` → `sum`=8'hE1, `cout`=0, no restart, single `done`.
- Assert `rst` for one cycle at RUN cycle 4 → next cycle `ready`=1, `sum`=0, `cout`=0, no `done`. Then 8'h12+8'h34, cin=0 → `sum`=8'h46.
- `start` held high for 50 cycles → `done` pulses every 10 cycles (WIDTH+2) with correct results; `sum`/`cout` stable between pulses.
- WIDTH=4 and WIDTH=1 instances: exhaustive a, b, cin (512 and 8 cases) checked against a+b+cin, with latency = WIDTH.
